// File: rtl/booth_pkg.sv
// ============================================================================
// Module   : booth_pkg
// Brief    : FSM state encoding and radix-2 Booth select codes.
// Revision : 1.0
// ============================================================================
`default_nettype none

package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_sel_t;

    // {Q[0], q_1}: 10 subtracts M, 01 adds M, 00/11 leave A alone
    function automatic booth_sel_t booth_decode(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b10:   return BOOTH_SUB;
            2'b01:   return BOOTH_ADD;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_step.sv
// ============================================================================
// Module   : booth_step
// Brief    : One combinational radix-2 Booth iteration: add/sub then ASR.
// Revision : 1.0
// ============================================================================
`default_nettype none

module booth_step
    import booth_pkg::*;
#(
    parameter int AW = 7,
    parameter int QW = 6
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] m,
    input  logic [QW-1:0] q,
    input  logic          q_1,
    output logic [AW-1:0] a_nxt,
    output logic [QW-1:0] q_nxt,
    output logic          q1_nxt
);

    booth_sel_t    w_sel;
    logic [AW-1:0] w_sum;

    always_comb begin
        w_sel = booth_decode(q[0], q_1);
        case (w_sel)
            BOOTH_ADD: w_sum = a + m;
            BOOTH_SUB: w_sum = a - m;
            default:   w_sum = a;
        endcase
    end

    // Arithmetic shift right of {A, Q, q_1} by one
    assign a_nxt  = {w_sum[AW-1], w_sum[AW-1:1]};
    assign q_nxt  = {w_sum[0], q[QW-1:1]};
    assign q1_nxt = q[0];

endmodule

`default_nettype wire

// File: rtl/seq_booth_multiplier.sv
// ============================================================================
// Module   : seq_booth_multiplier
// Brief    : Sequential radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH,
//            valid/ready on operands and product. BOOTH_UNSIGNED_EN adds op_signed.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_booth_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
`ifdef BOOTH_UNSIGNED_EN
    ,
    input  logic               op_signed
`endif
);

`ifdef BOOTH_UNSIGNED_EN
    localparam int EXT    = 1;
`else
    localparam int EXT    = 0;
`endif
    localparam int N_ITER = WIDTH + EXT;
    localparam int CNT_W  = $clog2(N_ITER + 1);
    localparam int AW     = WIDTH + 1 + EXT;
    localparam int QW     = WIDTH + EXT;

    localparam logic [CNT_W-1:0] c_last_step = CNT_W'(N_ITER - 1);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [AW-1:0]        r_a;
    logic [AW-1:0]        r_m;
    logic [QW-1:0]        r_q;
    logic                 r_q1;
    logic                 r_out_valid;
    logic [2*WIDTH-1:0]   r_product;

    logic [AW-1:0]        w_a_nxt;
    logic [QW-1:0]        w_q_nxt;
    logic                 w_q1_nxt;
    logic [AW-1:0]        w_m_ld;
    logic [QW-1:0]        w_q_ld;
    logic [2*WIDTH-1:0]   w_prod;

`ifdef BOOTH_UNSIGNED_EN
    logic w_ms;
    logic w_qs;
    assign w_ms   = op_signed & multiplicand[WIDTH-1];
    assign w_qs   = op_signed & multiplier[WIDTH-1];
    assign w_m_ld = {w_ms, w_ms, multiplicand};
    assign w_q_ld = {w_qs, multiplier};
`else
    // One guard bit on M keeps -M of the most-negative operand representable
    assign w_m_ld = {multiplicand[WIDTH-1], multiplicand};
    assign w_q_ld = multiplier;
`endif

    booth_step #(
        .AW (AW),
        .QW (QW)
    ) u_step (
        .a      (r_a),
        .m      (r_m),
        .q      (r_q),
        .q_1    (r_q1),
        .a_nxt  (w_a_nxt),
        .q_nxt  (w_q_nxt),
        .q1_nxt (w_q1_nxt)
    );

    assign w_prod    = {w_a_nxt[2*WIDTH-QW-1:0], w_q_nxt};
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign product   = r_product;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_m         <= '0;
            r_q         <= '0;
            r_q1        <= 1'b0;
            r_out_valid <= 1'b0;
            r_product   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= '0;
                        r_m     <= w_m_ld;
                        r_q     <= w_q_ld;
                        r_q1    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_a   <= w_a_nxt;
                    r_q   <= w_q_nxt;
                    r_q1  <= w_q1_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_last_step) begin
                        r_product   <= w_prod;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_booth_multiplier.sv
// ============================================================================
// Module   : tb_seq_booth_multiplier
// Brief    : Directed self-checking bench for seq_booth_multiplier (WIDTH=6).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_booth_multiplier;

    localparam int W = 6;
`ifdef BOOTH_UNSIGNED_EN
    localparam int N = W + 1;
`else
    localparam int N = W;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   mc = '0;
    logic [W-1:0]   mp = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] product;
    logic           op_signed = 1'b1;

    int total = 0;
    int bad   = 0;

    seq_booth_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (mc),
        .multiplier   (mp),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product)
`ifdef BOOTH_UNSIGNED_EN
        ,
        .op_signed    (op_signed)
`endif
    );

    always #5 clk = ~clk;

    // Presents an operand pair and returns after the accepting edge
    task automatic accept_op(input logic [W-1:0] m, input logic [W-1:0] q, output bit ok);
        int n = 0;
        mc = m;
        mp = q;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ok = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++;
        if (product !== 12'h000) begin bad++; $display("FAIL reset_product got=%h want=000", product); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [W-1:0]   m;
        logic [W-1:0]   q;
        logic [2*W-1:0] p;
    } vec_t;

    task automatic test_products();
        vec_t v[5];
        bit   ok;
        int   cyc;
        v[0] = '{6'h07, 6'h3D, 12'hFEB};   //  7 * -3
        v[1] = '{6'h20, 6'h20, 12'h400};   // -32 * -32
        v[2] = '{6'h20, 6'h1F, 12'hC20};   // -32 * 31
        v[3] = '{6'h00, 6'h3F, 12'h000};   //  0 * -1
        v[4] = '{6'h3F, 6'h3F, 12'h001};   // -1 * -1
        for (int i = 0; i < 5; i++) begin
            accept_op(v[i].m, v[i].q, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL prod%0d_accept in_ready never rose", i); end
            wait_done(cyc);
            total++;
            if (cyc != N) begin bad++; $display("FAIL prod%0d_latency got=%0d want=%0d", i, cyc, N); end
            total++;
            if (product !== v[i].p) begin bad++; $display("FAIL prod%0d_value got=%h want=%h", i, product, v[i].p); end
            take();
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL prod%0d_handoff out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        accept_op(6'h02, 6'h03, ok);
        wait_done(cyc);
        total++;
        if (product !== 12'h006) begin bad++; $display("FAIL bp_first got=%h want=006", product); end
        mc = 6'h3C;  // -4
        mp = 6'h05;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (product !== 12'h006 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d product=%h out_valid=%b in_ready=%b want 006/1/0",
                         i, product, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_handoff out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_second_accept in_ready=%b want 0", in_ready); end
        wait_done(cyc);
        total++;
        if (cyc != N) begin bad++; $display("FAIL bp_second_latency got=%0d want=%0d", cyc, N); end
        total++;
        if (product !== 12'hFEC) begin bad++; $display("FAIL bp_second_value got=%h want=fec", product); end
        take();
    endtask

    task automatic test_reset_abort();
        bit ok;
        int cyc;
        accept_op(6'h09, 6'h09, ok);
        repeat (2) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_busy out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_no_stale out_valid=%b want 0", out_valid); end
        // Abort while a product is being held
        accept_op(6'h03, 6'h07, ok);
        wait_done(cyc);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || product !== 12'h000 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_done out_valid=%b product=%h in_ready=%b want 0/000/1",
                     out_valid, product, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        accept_op(6'h05, 6'h05, ok);
        wait_done(cyc);
        total++;
        if (cyc != N || product !== 12'h019) begin
            bad++;
            $display("FAIL abort_next latency=%0d product=%h want %0d/019", cyc, product, N);
        end
        take();
    endtask

`ifdef BOOTH_UNSIGNED_EN
    task automatic test_unsigned();
        bit ok;
        int cyc;
        op_signed = 1'b0;
        accept_op(6'h3F, 6'h3F, ok);
        wait_done(cyc);
        total++;
        if (cyc != 7) begin bad++; $display("FAIL uns_latency got=%0d want=7", cyc); end
        total++;
        if (product !== 12'hF81) begin bad++; $display("FAIL uns_value got=%h want=f81", product); end
        take();
        op_signed = 1'b1;
        accept_op(6'h3F, 6'h3F, ok);
        wait_done(cyc);
        total++;
        if (product !== 12'h001) begin bad++; $display("FAIL sgn_value got=%h want=001", product); end
        take();
    endtask
`endif

    initial begin
        test_reset();
        test_products();
        test_back_to_back();
        test_reset_abort();
`ifdef BOOTH_UNSIGNED_EN
        test_unsigned();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
